// File: rtl/drum_voice_if.sv
`default_nettype none
// ============================================================================
// drum_voice_if : play controls from the sequencer, audio sample to the mixer
// Revision      : 1.0
// ============================================================================
interface drum_voice_if;
  logic              en;
  logic              go;
  logic              mode;
  logic signed [7:0] out;
  logic              busy;

  modport master (output en, go, mode, input out, busy);
  modport slave  (input en, go, mode, output out, busy);
endinterface
`default_nettype wire

// File: rtl/drum_voice.sv
`default_nettype none
// ============================================================================
// drum_voice : one-shot percussive voice, square tone or LFSR noise under a
//              decaying envelope. Optional kick pitch sweep: DRUM_VOICE_PITCH_SWEEP_EN
// Revision   : 1.0
// ============================================================================
module drum_voice #(
  parameter int CLK_DIV     = 1042,
  parameter int DECAY_SHIFT = 4,
  parameter int TONE_HALF   = 64
) (
  input  wire logic   clk,
  input  wire logic   reset,
  drum_voice_if.slave bus
);

  localparam int              CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [7:0]      HALF_INIT = 8'(TONE_HALF);
  localparam logic [15:0]     LFSR_SEED = 16'hACE1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   strobe_cnt;
  logic               strobe;
  logic               go_q;
  logic               trigger;
  logic [7:0]         env;
  logic [8:0]         env_diff;
  logic [7:0]         env_next;
  logic [7:0]         tone_cnt;
  logic [7:0]         half;
  logic [7:0]         half_last;
  logic               phase_pos;
  logic [15:0]        lfsr;
  logic               lfsr_fb;
  logic signed [7:0]  src;
  logic signed [16:0] product;
  logic signed [7:0]  sample;
  logic               unused_product;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobe_cnt <= '0;
    end else if (strobe) begin
      strobe_cnt <= '0;
    end else begin
      strobe_cnt <= strobe_cnt + 1'b1;
    end
  end

  assign strobe  = (strobe_cnt == CNT_LAST);
  assign trigger = bus.go & ~go_q & bus.en;

  // Env is at least 1 while playing, so the borrow bit only guards misuse.
  assign env_diff = {1'b0, env} - {1'b0, (env >> DECAY_SHIFT)} - 9'd1;
  assign env_next = env_diff[8] ? 8'd0 : env_diff[7:0];

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    src = phase_pos ? 8'sd127 : -8'sd127;
    if (bus.mode) begin
      src = signed'(lfsr[7:0]);
    end
  end

  assign product        = 17'(src) * 17'(signed'({1'b0, env}));
  assign unused_product = ^{product[16], product[7:0]};
  assign half_last      = half - 8'd1;

`ifdef DRUM_VOICE_PITCH_SWEEP_EN
  logic [3:0] sweep_cnt;

  // Half-period grows by one every 16 strobes of a note, lowering the pitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sweep_cnt <= '0;
      half      <= HALF_INIT;
    end else if (trigger) begin
      sweep_cnt <= '0;
      half      <= HALF_INIT;
    end else if (state == PLAY && strobe) begin
      sweep_cnt <= sweep_cnt + 4'd1;
      if (&sweep_cnt && half != 8'hFF) begin
        half <= half + 8'd1;
      end
    end
  end
`else
  assign half = HALF_INIT;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sample    <= '0;
      env       <= '0;
      tone_cnt  <= '0;
      phase_pos <= 1'b1;
      go_q      <= 1'b0;
      lfsr      <= LFSR_SEED;
    end else begin
      go_q <= bus.go;
      if (strobe) begin
        lfsr <= {lfsr[14:0], lfsr_fb};
      end
      if (!bus.en) begin
        state  <= IDLE;
        sample <= '0;
        env    <= '0;
      end else begin
        case (state)
          IDLE: sample <= '0;
          PLAY: begin
            if (strobe) begin
              env <= env_next;
              if (tone_cnt == half_last) begin
                tone_cnt  <= '0;
                phase_pos <= ~phase_pos;
              end else begin
                tone_cnt <= tone_cnt + 8'd1;
              end
              if (env_next == 8'd0 && !trigger) begin
                state  <= IDLE;
                sample <= '0;
              end else begin
                sample <= product[15:8];
              end
            end
          end
          default: state <= IDLE;
        endcase
        // A trigger restarts the note and overrides a same-cycle decay end.
        if (trigger) begin
          state     <= PLAY;
          env       <= 8'hFF;
          tone_cnt  <= '0;
          phase_pos <= 1'b1;
        end
      end
    end
  end

  assign bus.out  = sample;
  assign bus.busy = (state == PLAY);

endmodule
`default_nettype wire

// File: tb/tb_drum_voice.sv
`default_nettype none
// ============================================================================
// tb_drum_voice : randomized scoreboard bench against a strobe-level model
// Revision      : 1.0
// ============================================================================
module tb_drum_voice;

  localparam int DIV   = 8;
  localparam int SHIFT = 4;
  localparam int HALF  = 6;
`ifdef DRUM_VOICE_PITCH_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  drum_voice_if bus ();

  drum_voice #(.CLK_DIV(DIV), .DECAY_SHIFT(SHIFT), .TONE_HALF(HALF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int o;
    bit b;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference: envelope as a precomputed table indexed by strobes into the note.
  int env_seq[0:511];
  int cyc, mk, tcnt, lfsr, mout;
  bit play, pos, goq;

  function automatic int floor256(int p);
    return (p >= 0) ? p / 256 : -((-p + 255) / 256);
  endfunction

  task automatic step();
    bit strobe, trig;
    int s, h;
    if (!reset) begin
      cyc = 0; goq = 0; lfsr = 16'hACE1; play = 0; mout = 0; mk = 0; tcnt = 0; pos = 1;
    end else begin
      strobe = (cyc == DIV - 1);
      trig   = bus.en && bus.go && !goq;
      if (bus.mode) begin
        s = lfsr & 255;
        if (s > 127) s = s - 256;
      end else begin
        s = pos ? 127 : -127;
      end
      if (!bus.en) begin
        play = 0;
        mout = 0;
      end else if (play && strobe) begin
        if (env_seq[mk + 1] == 0 && !trig) begin
          play = 0;
          mout = 0;
        end else begin
          mout = floor256(s * env_seq[mk]);
          h = HALF + (SWEEP ? mk / 16 : 0);
          if (h > 255) h = 255;
          if (tcnt == h - 1) begin
            tcnt = 0;
            pos  = !pos;
          end else begin
            tcnt++;
          end
          if (mk < 510) mk++;
        end
      end else if (!play) begin
        mout = 0;
      end
      if (trig) begin
        play = 1; mk = 0; tcnt = 0; pos = 1;
      end
      goq = bus.go;
      if (strobe) lfsr = ((lfsr << 1) | (((lfsr >> 15) ^ (lfsr >> 13) ^ (lfsr >> 12) ^ (lfsr >> 10)) & 1)) & 16'hFFFF;
      cyc = strobe ? 0 : cyc + 1;
    end
    q.push_back('{o: mout, b: play});
  endtask

  initial begin
    int e;
    e = 255;
    for (int k = 0; k < 512; k++) begin
      env_seq[k] = e;
      e = e - (e >> SHIFT) - 1;
      if (e < 0) e = 0;
    end
    forever begin
      @(posedge clk);
      step();
    end
  end

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        total++;
        if ($signed(bus.out) != x.o || bus.busy !== x.b) begin
          bad++;
          $display("FAIL sample t=%0t out=%0d busy=%0b expected out=%0d busy=%0b",
                   $time, $signed(bus.out), bus.busy, x.o, x.b);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_go();
    bus.go = 1'b1;
    wait_cyc(1);
    bus.go = 1'b0;
  endtask

  initial begin
    bit found;
    reset    = 1'b0;
    bus.en   = 1'b1;
    bus.go   = 1'b0;
    bus.mode = 1'b0;
    wait_cyc(3);
    total++;
    if (bus.out !== 8'sd0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state out=%0d busy=%0b expected out=0 busy=0", $signed(bus.out), bus.busy);
    end
    reset = 1'b1;
    wait_cyc(10 * DIV);

    // Square-tone note decaying to its end
    pulse_go();
    wait_cyc(70 * DIV);

    // Held level gives a single trigger, then a retrigger mid-decay
    bus.go = 1'b1;
    wait_cyc(5 * DIV);
    bus.go = 1'b0;
    wait_cyc(10 * DIV);
    pulse_go();
    wait_cyc(20 * DIV);

    // Source switch mid-note
    bus.mode = 1'b1;
    wait_cyc(10 * DIV);
    bus.mode = 1'b0;
    wait_cyc(5 * DIV);

    // Disable mid-note, go edge while disabled
    bus.en = 1'b0;
    wait_cyc(3);
    pulse_go();
    wait_cyc(3 * DIV);
    bus.en = 1'b1;
    wait_cyc(5 * DIV);

    // Retrigger on the very strobe where the envelope would hit zero
    pulse_go();
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (play && cyc == DIV - 1 && env_seq[mk + 1] == 0) found = 1'b1;
    end
    #1;
    total++;
    if (!found) begin
      bad++;
      $display("FAIL retrig_setup reached=0 required=1");
    end
    pulse_go();
    wait_cyc(5 * DIV);

    // Reset in the middle of a note
    reset = 1'b0;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(10 * DIV);

    for (int i = 0; i < 300; i++) begin
      bus.en   = ($urandom_range(0, 19) != 0);
      bus.mode = 1'($urandom_range(0, 1));
      bus.go   = 1'($urandom_range(0, 1));
      wait_cyc($urandom_range(1, 3 * DIV));
    end
    bus.en = 1'b1;
    bus.go = 1'b0;
    pulse_go();
    wait_cyc(80 * DIV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
